// File: rtl/al_buckeye_readback_if.sv
// Control, serial-chain and readback-FIFO signals of the Buckeye readback block.
// The slave modport is the readback engine; master is whatever drives it.
interface al_buckeye_readback_if;
  logic        START;
  logic        CLR_RB_DONE;
  logic        SDOUT;
  logic        FIFO_FULL;
  logic        SHCK;
  logic        RB_ENA;
  logic        FIFO_WE;
  logic [15:0] FIFO_DIN;
  logic        RB_DONE;
  logic        RB_OVFL;

  modport slave (
    input  START, CLR_RB_DONE, SDOUT, FIFO_FULL,
    output SHCK, RB_ENA, FIFO_WE, FIFO_DIN, RB_DONE, RB_OVFL
  );

  modport master (
    output START, CLR_RB_DONE, SDOUT, FIFO_FULL,
    input  SHCK, RB_ENA, FIFO_WE, FIFO_DIN, RB_DONE, RB_OVFL
  );
endinterface

// File: rtl/al_buckeye_readback.sv
// Buckeye daisy-chain readback: drives SHCK, samples SDOUT at the end of each low
// phase, packs 16 bits LSB-first per word and writes NWORDS words to the readback FIFO.
module al_buckeye_readback #(
  parameter int CLK_DIV = 40,
  parameter int NWORDS  = 54
) (
  input  logic                  CLK40,
  input  logic                  RST,
  al_buckeye_readback_if.slave  rb
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int WW = $clog2(NWORDS + 1);
  localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DHALF = DW'(CLK_DIV / 2);
  localparam logic [WW-1:0] WLAST = WW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [3:0]      bcnt_q, bcnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [15:0]     sr_q, sr_d;
  logic [15:0]     din_q, din_d;
  logic            wrdy_q, wrdy_d;
  logic            shck_q, shck_d;
  logic            rb_ena_q, rb_ena_d;
  logic            rb_done_q, rb_done_d;
  logic            rb_ovfl_q, rb_ovfl_d;
  logic            set_done;

  always_ff @(posedge CLK40 or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      bcnt_q    <= '0;
      wcnt_q    <= '0;
      sr_q      <= '0;
      din_q     <= '0;
      wrdy_q    <= 1'b0;
      shck_q    <= 1'b0;
      rb_ena_q  <= 1'b0;
      rb_done_q <= 1'b0;
      rb_ovfl_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      bcnt_q    <= bcnt_d;
      wcnt_q    <= wcnt_d;
      sr_q      <= sr_d;
      din_q     <= din_d;
      wrdy_q    <= wrdy_d;
      shck_q    <= shck_d;
      rb_ena_q  <= rb_ena_d;
      rb_done_q <= rb_done_d;
      rb_ovfl_q <= rb_ovfl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    bcnt_d    = bcnt_q;
    wcnt_d    = wcnt_q;
    sr_d      = sr_q;
    din_d     = din_q;
    wrdy_d    = 1'b0;
    shck_d    = 1'b0;
    rb_ovfl_d = rb_ovfl_q;
    set_done  = 1'b0;

    // A completed word is offered for exactly one cycle; a full FIFO drops it.
    if (wrdy_q) begin
      wcnt_d = wcnt_q + 1'b1;
      if (rb.FIFO_FULL) begin
        rb_ovfl_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rb.START) begin
          state_d   = SHIFT;
          dcnt_d    = '0;
          bcnt_d    = '0;
          wcnt_d    = '0;
          rb_ovfl_d = 1'b0;
        end
      end
      SHIFT: begin
        shck_d = (dcnt_q < DHALF);
        dcnt_d = (dcnt_q == DLAST) ? '0 : dcnt_q + 1'b1;
        // Sample at the end of the low phase, just before the next rising edge.
        if (dcnt_q == DLAST) begin
          sr_d   = {rb.SDOUT, sr_q[15:1]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 4'd15) begin
            din_d  = sr_d;
            wrdy_d = 1'b1;
            if (wcnt_q == WLAST) begin
              state_d = FINISH;
            end
          end
        end
      end
      FINISH: begin
        set_done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rb_ena_d = (state_d != IDLE);

    if (rb.CLR_RB_DONE) begin
      rb_done_d = 1'b0;
    end else if (set_done) begin
      rb_done_d = 1'b1;
    end else begin
      rb_done_d = rb_done_q;
    end
  end

  assign rb.SHCK     = shck_q;
  assign rb.RB_ENA   = rb_ena_q;
  assign rb.FIFO_WE  = wrdy_q & ~rb.FIFO_FULL;
  assign rb.FIFO_DIN = din_q;
  assign rb.RB_DONE  = rb_done_q;
  assign rb.RB_OVFL  = rb_ovfl_q;

endmodule

// File: tb/tb_al_buckeye_readback.sv
// Bench for al_buckeye_readback: a small (CLK_DIV=4, NWORDS=2) instance with a
// modelled Buckeye chain and a default-parameter instance fed a constant-1 chain.
module tb_al_buckeye_readback;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  al_buckeye_readback_if ifa ();
  al_buckeye_readback_if ifb ();

  al_buckeye_readback #(.CLK_DIV(4), .NWORDS(2)) dut_a (.CLK40(clk), .RST(rst), .rb(ifa));
  al_buckeye_readback dut_b (.CLK40(clk), .RST(rst), .rb(ifb));

  assign ifb.SDOUT       = 1'b1;
  assign ifb.FIFO_FULL   = 1'b0;
  assign ifb.CLR_RB_DONE = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Chain model for instance A: two preloaded words, one bit emerges per SHCK rise.
  logic [15:0] words_a [2];
  bit          plan_a  [2];
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int rise_a = 0, rises_done_a = 0, wr_cnt_a = 0;
  int rise_b = 0, rises_done_b = 0, wr_cnt_b = 0, last_rise_b = -1;
  logic shck_prev_a = 1'b0, ena_prev_a = 1'b0;
  logic shck_prev_b = 1'b0, ena_prev_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    // Scoreboard monitors
    if (ifa.FIFO_WE === 1'b1) begin
      wr_cnt_a++;
      check("a_write_expected", (exp_a.size() != 0), 1);
      if (exp_a.size() != 0) check("a_fifo_din", ifa.FIFO_DIN, exp_a.pop_front());
      $display("[TB] A write %04h", ifa.FIFO_DIN);
    end
    if (ifb.FIFO_WE === 1'b1) begin
      wr_cnt_b++;
      check("b_write_expected", (exp_b.size() != 0), 1);
      if (exp_b.size() != 0) check("b_fifo_din", ifb.FIFO_DIN, exp_b.pop_front());
    end

    if (ifa.SHCK === 1'b1 && shck_prev_a == 1'b0) begin
      int widx, bidx;
      rise_a++;
      widx = (rise_a - 1) / 16;
      bidx = (rise_a - 1) % 16;
      if (widx < 2) begin
        ifa.SDOUT = words_a[widx][bidx];
        if (bidx == 0) ifa.FIFO_FULL = plan_a[widx];
      end else begin
        ifa.SDOUT = 1'b0;
      end
    end
    shck_prev_a = ifa.SHCK;
    if (ifa.RB_ENA !== 1'b1) begin
      if (ena_prev_a) rises_done_a = rise_a;
      rise_a = 0;
      ifa.FIFO_FULL = plan_a[0];
      ifa.SDOUT = 1'b0;
    end
    ena_prev_a = (ifa.RB_ENA === 1'b1);

    if (ifb.RB_ENA === 1'b1) begin
      if (ifb.SHCK === 1'b1 && shck_prev_b == 1'b0) begin
        rise_b++;
        if (last_rise_b >= 0) check("b_shck_period", cyc - last_rise_b, 40);
        last_rise_b = cyc;
      end
      if (ifb.SHCK === 1'b0 && shck_prev_b == 1'b1) check("b_shck_high", cyc - last_rise_b, 20);
    end else begin
      if (ena_prev_b) rises_done_b = rise_b;
      rise_b = 0;
      last_rise_b = -1;
    end
    shck_prev_b = (ifb.SHCK === 1'b1);
    ena_prev_b  = (ifb.RB_ENA === 1'b1);
  end

  // fin_act: 0 nothing, 1 CLR_RB_DONE in the done cycle, 2 START in the done cycle
  task automatic run_op_a(input logic [15:0] w0, input logic [15:0] w1, input bit f0,
                          input bit f1, input bit mid_start, input int fin_act);
    int n, wr0, fin_cyc;
    bit fin_seen, ms_done;
    logic done_before;
    words_a[0] = w0; words_a[1] = w1;
    plan_a[0] = f0;  plan_a[1] = f1;
    if (!f0) exp_a.push_back(w0);
    if (!f1) exp_a.push_back(w1);
    wr0 = wr_cnt_a;
    done_before = ifa.RB_DONE;
    fin_seen = 0; ms_done = 0; fin_cyc = 0;
    $display("[TB] A op words %04h %04h full %0d%0d mid_start %0d fin_act %0d", w0, w1, f0, f1, mid_start, fin_act);
    @(negedge clk); #1;
    ifa.START = 1'b1;
    @(negedge clk); #1;
    ifa.START = 1'b0;
    check("a_rb_ena_after_start", ifa.RB_ENA, 1);
    check("a_shck_low_after_start", ifa.SHCK, 0);
    check("a_done_not_cleared_by_start", ifa.RB_DONE, done_before);
    check("a_ovfl_cleared_by_start", ifa.RB_OVFL, 0);
    @(negedge clk); #1;
    check("a_first_shck_rise", ifa.SHCK, 1);
    for (n = 0; n < 2000; n++) begin
      @(negedge clk); #1;
      ifa.START = 1'b0;
      ifa.CLR_RB_DONE = 1'b0;
      if (ifa.RB_ENA !== 1'b1 || fin_seen) break;
      if (mid_start && rise_a == 8 && !ms_done) begin
        ifa.START = 1'b1;
        ms_done = 1;
      end
      if (ifa.FIFO_WE === 1'b1 && rise_a == 32) begin
        fin_seen = 1;
        fin_cyc = cyc;
        if (!done_before) check("a_done_not_early", ifa.RB_DONE, 0);
        if (fin_act == 1) ifa.CLR_RB_DONE = 1'b1;
        if (fin_act == 2) ifa.START = 1'b1;
      end
    end
    if (n >= 2000) begin
      check("a_op_timeout", 1, 0);
      return;
    end
    check("a_rb_ena_off", ifa.RB_ENA, 0);
    if (!f1) begin
      check("a_final_write_seen", fin_seen, 1);
      check("a_done_latency", cyc - fin_cyc, 1);
    end
    check("a_rb_done", ifa.RB_DONE, (fin_act == 1) ? 0 : 1);
    check("a_rb_ovfl", ifa.RB_OVFL, f0 | f1);
    check("a_shck_rises", rises_done_a, 32);
    check("a_write_count", wr_cnt_a - wr0, 32'(!f0) + 32'(!f1));
    check("a_scoreboard_empty", exp_a.size(), 0);
    if (fin_act != 0) begin
      @(negedge clk); #1;
      check("a_idle_after_done_cycle", ifa.RB_ENA, 0);
      check("a_done_after_done_cycle", ifa.RB_DONE, (fin_act == 1) ? 0 : 1);
    end
  endtask

  task automatic clr_done_a();
    check("a_done_before_clr", ifa.RB_DONE, 1);
    ifa.CLR_RB_DONE = 1'b1;
    @(negedge clk); #1;
    ifa.CLR_RB_DONE = 1'b0;
    check("a_done_after_clr", ifa.RB_DONE, 0);
    $display("[TB] A clear done -> %0d", ifa.RB_DONE);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_outs"}, {ifa.SHCK, ifa.RB_ENA, ifa.FIFO_WE, ifa.RB_DONE, ifa.RB_OVFL}, 0);
    check({tag, "_a_din"}, ifa.FIFO_DIN, 0);
    check({tag, "_b_outs"}, {ifb.SHCK, ifb.RB_ENA, ifb.FIFO_WE, ifb.RB_DONE, ifb.RB_OVFL}, 0);
    check({tag, "_b_din"}, ifb.FIFO_DIN, 0);
  endtask

  task automatic reset_mid_op_a();
    int n, wr0;
    words_a[0] = 16'($urandom); words_a[1] = 16'($urandom);
    plan_a[0] = 0; plan_a[1] = 0;
    wr0 = wr_cnt_a;
    @(negedge clk); #1;
    ifa.START = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk); #1;
      ifa.START = 1'b0;
      if (rise_a == 11) break;
    end
    if (n >= 500) begin
      check("a_reset_wait_timeout", 1, 0);
      return;
    end
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    $display("[TB] A reset after 10 samples");
    repeat (3) @(negedge clk);
    #1;
    check("a_no_write_in_reset", wr_cnt_a - wr0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    ifa.START = 1'b0;
    ifa.CLR_RB_DONE = 1'b0;
    ifb.START = 1'b0;
    words_a[0] = '0; words_a[1] = '0;
    plan_a[0] = 0; plan_a[1] = 0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_op_a(16'hA5C3, 16'h1234, 0, 0, 0, 0);
    clr_done_a();
    run_op_a(16'hA5C3, 16'h1234, 1, 0, 0, 0);
    run_op_a(16'hA5C3, 16'h1234, 0, 0, 1, 0);
    run_op_a(16'($urandom), 16'($urandom), 0, 0, 0, 1);
    run_op_a(16'($urandom), 16'($urandom), 0, 0, 0, 2);
    for (int i = 0; i < 6; i++) begin
      run_op_a(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) clr_done_a();
    end
    reset_mid_op_a();
    run_op_a(16'($urandom), 16'($urandom), 0, 0, 0, 0);

    for (int i = 0; i < 54; i++) exp_b.push_back(16'hFFFF);
    @(negedge clk); #1;
    ifb.START = 1'b1;
    @(negedge clk); #1;
    ifb.START = 1'b0;
    check("b_rb_ena_after_start", ifb.RB_ENA, 1);
    for (n = 0; n < 40000; n++) begin
      @(negedge clk); #1;
      if (ifb.RB_ENA !== 1'b1) break;
    end
    check("b_op_finished", (n < 40000), 1);
    check("b_shck_rises", rises_done_b, 864);
    check("b_write_count", wr_cnt_b, 54);
    check("b_scoreboard_empty", exp_b.size(), 0);
    check("b_rb_done", ifb.RB_DONE, 1);
    check("b_rb_ovfl", ifb.RB_OVFL, 0);
    $display("[TB] B op done: %0d rises, %0d writes", rises_done_b, wr_cnt_b);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/al_buckeye_readback.md
Name: al_buckeye_readback

Overview:
- Readback counterpart of the Buckeye shift-chain loader.
- On command, it generates the Buckeye shift clock and samples the serial data returned at the far end of the daisy chain.
- It assembles the bits into 16-bit words, LSB first, which is the same bit order the loader shifts out.
- It pushes each word into a readback FIFO for BPI/JTAG access, and signals completion with a sticky done flag.

Parameters:
- CLK_DIV, 40, CLK40 cycles per shift-clock period (40 gives 1 MHz); even, ≥4.
- NWORDS, 54, number of 16-bit words read per operation (6 Buckeyes × 144 bits = 864 bits).

Ports:
- CLK40  input  1  sole clock; all logic on posedge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle pulse; begins a readback when idle.
- CLR_RB_DONE  input  1  clears RB_DONE.
- SDOUT  input  1  serial data from the last Buckeye in the chain; pre-synchronised.
- FIFO_FULL  input  1  readback FIFO full.
- SHCK  output  1  registered shift clock to the Buckeye chain.
- RB_ENA  output  1  high while a readback is in progress.
- FIFO_WE  output  1  one-cycle FIFO write strobe.
- FIFO_DIN  output  16  assembled word; valid while FIFO_WE is high.
- RB_DONE  output  1  sticky completion flag.
- RB_OVFL  output  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:

Reset:
- Async RST forces state IDLE.
- All of SHCK, RB_ENA, FIFO_WE, RB_DONE, RB_OVFL are 0.
- FIFO_DIN, the shift register and all counters are 0.
- RST mid-operation aborts immediately; no partial word is written.

State IDLE:
- SHCK=0, RB_ENA=0.
- START → SHIFT.
- On that transition: clear dcnt, bit counter, word counter and RB_OVFL; RB_ENA goes 1 on the next cycle.

State SHIFT:
- dcnt counts 0..CLK_DIV-1 and wraps.
- SHCK (registered) is high when dcnt < CLK_DIV/2, low otherwise. The first rising edge of SHCK appears 1 cycle after entering SHIFT.
- Sample point: when dcnt == CLK_DIV-1 (end of the low phase), shift in the sample: sr <= {SDOUT, sr[15:1]}; bit counter increments.
- On the 16th sample (bit counter 15→0), the next cycle drives FIFO_DIN = completed word with FIFO_WE=1 for exactly one cycle, and the word counter increments.
- If FIFO_FULL=1 in the cycle FIFO_WE would assert: FIFO_WE stays 0, the word is discarded, RB_OVFL is set (sticky until the next START), and the word counter still increments.
- After the NWORDS-th word completes → FINISH. SHCK is held 0 from the cycle after the final sample; no further SHCK edges occur.

State FINISH (1 cycle):
- The final FIFO write (if any) occurs.
- Pulse set_done; RB_ENA goes 0 next cycle → IDLE.
- Total SHCK rising edges per operation = 16·NWORDS exactly.

RB_DONE:
- Set by set_done; cleared by CLR_RB_DONE.
- CLR_RB_DONE wins when both occur in the same cycle.

START handling:
- START while RB_ENA=1 is ignored; no restart, counters untouched.
- START in the same cycle as set_done is ignored.
- START does not clear RB_DONE.

Latency:
- START to first SHCK rise: 2 cycles.
- Last sample to FIFO_WE: 1 cycle.
- Last sample to RB_DONE high: 2 cycles.

Width rules:
- The word counter is sized ceil(log2(NWORDS+1)) and never wraps.
- The bit counter is 4 bits.
- dcnt is sized ceil(log2(CLK_DIV)).

Test Plan:
1. Nominal word: CLK_DIV=4, NWORDS=2, SDOUT driven by a model chain preloaded with 0xA5C3 then 0x1234, shifting on SHCK rise → FIFO writes 0xA5C3 then 0x1234; 32 SHCK rises; RB_DONE=1 two cycles after the last sample; RB_OVFL=0.
2. Full FIFO: same stimulus with FIFO_FULL=1 during the first word completion → only 0x1234 written; RB_OVFL=1; RB_DONE=1; word count still 2 (no extra SHCK edges).
3. Done handshake: after completion assert CLR_RB_DONE → RB_DONE=0 next cycle. Assert CLR_RB_DONE in the set_done cycle → RB_DONE stays 0.
4. START while busy: pulse START mid-word 1 → no restart; total SHCK rises still 32; data is 0xA5C3, 0x1234.
5. Reset mid-operation: assert RST after 10 sample points → all outputs 0 immediately; no FIFO_WE. A new START then reads 2 full words correctly from a reloaded chain.
6. Defaults: CLK_DIV=40, NWORDS=54, SDOUT=1 constant → 54 writes of 0xFFFF; SHCK period 40 cycles with 50% duty; 864 rises; RB_DONE=1.
